// File: rtl/mem_req_ctrl.sv
// Data-memory requester for the Y86-64 memory stage: decodes the access, runs a req/ack
// handshake and returns val_m. Optional MEM_TIMEOUT_EN aborts requests left unacknowledged.
module mem_req_ctrl #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  in_code,
    input  logic [63:0] val_e,
    input  logic [63:0] val_a,
    input  logic [63:0] val_p,
    output logic        busy,
    output logic        done,
    output logic [63:0] val_m,
    output logic [63:0] mem_add,
    output logic        bad_mem,
    output logic        dm_req,
    output logic        dm_we,
    output logic [63:0] dm_addr,
    output logic [63:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [63:0] dm_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    // A zero TIMEOUT would expire immediately, so it is treated as "never time out".
    localparam bit TIMEOUT_ON = (TIMEOUT != 0);

    state_t      state, state_nxt;
    logic        busy_nxt, done_nxt, bad_mem_nxt, dm_req_nxt, dm_we_nxt;
    logic [63:0] val_m_nxt, mem_add_nxt, dm_addr_nxt, dm_wdata_nxt;

    logic        is_mem, is_write, in_range, timeout_hit;
    logic [63:0] addr, wdata;

    always_comb begin
        is_mem   = 1'b0;
        is_write = 1'b0;
        addr     = val_e;
        wdata    = val_a;
        case (in_code)
            4'd4:  begin is_mem = 1'b1; is_write = 1'b1; end
            4'd5:  begin is_mem = 1'b1; end
            4'd8:  begin is_mem = 1'b1; is_write = 1'b1; wdata = val_p; end
            4'd9:  begin is_mem = 1'b1; addr = val_a; end
            4'd10: begin is_mem = 1'b1; is_write = 1'b1; end
            4'd11: begin is_mem = 1'b1; addr = val_a; end
            default: ;
        endcase
    end

    assign in_range = (addr < 64'(MEM_WORDS));

`ifdef MEM_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

    logic [CW-1:0] req_cnt;

    // Counts completed REQ cycles; restarts whenever the FSM is outside REQ.
    always_ff @(posedge clock) begin
        if (reset || state != REQ) begin
            req_cnt <= '0;
        end else begin
            req_cnt <= req_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == REQ) && (req_cnt == CW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        val_m_nxt    = val_m;
        mem_add_nxt  = mem_add;
        bad_mem_nxt  = bad_mem;
        dm_req_nxt   = dm_req;
        dm_we_nxt    = dm_we;
        dm_addr_nxt  = dm_addr;
        dm_wdata_nxt = dm_wdata;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!is_mem) begin
                        bad_mem_nxt = 1'b0;
                        done_nxt    = 1'b1;
                    end else if (!in_range) begin
                        mem_add_nxt = addr;
                        bad_mem_nxt = 1'b1;
                        done_nxt    = 1'b1;
                    end else begin
                        mem_add_nxt  = addr;
                        bad_mem_nxt  = 1'b0;
                        dm_addr_nxt  = addr;
                        dm_we_nxt    = is_write;
                        dm_wdata_nxt = wdata;
                        dm_req_nxt   = 1'b1;
                        busy_nxt     = 1'b1;
                        state_nxt    = REQ;
                    end
                end
            end
            REQ: begin
                // An ack in the expiry cycle takes priority over the timeout.
                if (dm_ack) begin
                    dm_req_nxt = 1'b0;
                    if (!dm_we) begin
                        val_m_nxt = dm_rdata;
                    end
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = RESP;
                end else if (TIMEOUT_ON && timeout_hit) begin
                    dm_req_nxt  = 1'b0;
                    bad_mem_nxt = 1'b1;
                    busy_nxt    = 1'b0;
                    done_nxt    = 1'b1;
                    state_nxt   = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            val_m    <= '0;
            mem_add  <= '0;
            bad_mem  <= 1'b0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
        end else begin
            state    <= state_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            val_m    <= val_m_nxt;
            mem_add  <= mem_add_nxt;
            bad_mem  <= bad_mem_nxt;
            dm_req   <= dm_req_nxt;
            dm_we    <= dm_we_nxt;
            dm_addr  <= dm_addr_nxt;
            dm_wdata <= dm_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed and random accesses against a transaction-level
// model with a backing word memory. Honours MEM_TIMEOUT_EN when defined.
module tb_mem_req_ctrl;

    localparam int unsigned WORDS = 1024;
    localparam int unsigned TMO   = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  inCode = '0;
    logic [63:0] valE = '0, valA = '0, valP = '0;
    logic        busy, done, badMem, dmReq, dmWe;
    logic [63:0] valM, memAdd, dmAddr, dmWdata;
    logic        dmAck = 1'b0;
    logic [63:0] dmRdata = '0;

    int checkCount = 0;
    int passCount  = 0;

    logic [63:0] tbMem [0:WORDS-1];
    logic [63:0] expValM   = '0;
    logic [63:0] expMemAdd = '0;
    logic        expBad    = 1'b0;

    mem_req_ctrl #(.MEM_WORDS(WORDS), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .start(start), .in_code(inCode),
        .val_e(valE), .val_a(valA), .val_p(valP),
        .busy(busy), .done(done), .val_m(valM), .mem_add(memAdd), .bad_mem(badMem),
        .dm_req(dmReq), .dm_we(dmWe), .dm_addr(dmAddr), .dm_wdata(dmWdata),
        .dm_ack(dmAck), .dm_rdata(dmRdata)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Y86 memory-stage semantics: which instructions touch memory, and with what.
    function automatic void refDecode(input logic [3:0] code, input logic [63:0] ve, va, vp,
                                      output bit isMem, output bit isWr,
                                      output logic [63:0] a, output logic [63:0] d);
        isMem = 1'b1; isWr = 1'b0; a = ve; d = va;
        if (code == 4'd4 || code == 4'd10) isWr = 1'b1;
        else if (code == 4'd8) begin isWr = 1'b1; d = vp; end
        else if (code == 4'd9 || code == 4'd11) a = va;
        else if (code != 4'd5) isMem = 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkIdleState(input string tag);
        checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
        checkOutput({tag, ".req"}, 64'(dmReq), 64'd0);
        checkOutput({tag, ".valm"}, valM, expValM);
        checkOutput({tag, ".memadd"}, memAdd, expMemAdd);
        checkOutput({tag, ".bad"}, 64'(badMem), 64'(expBad));
    endtask

    // One complete access: present start for a cycle, answer as memory after ackDelay idle cycles.
    task automatic applyStimulus(input string tag, input logic [3:0] code,
                                 input logic [63:0] ve, va, vp, input int ackDelay);
        bit          isMem, isWr;
        logic [63:0] a, d, rdata;
        refDecode(code, ve, va, vp, isMem, isWr, a, d);
        start = 1'b1; inCode = code; valE = ve; valA = va; valP = vp;
        tick();
        start = 1'b0; inCode = 4'($urandom); valE = rand64(); valA = rand64(); valP = rand64();
        if (!isMem || a >= 64'(WORDS)) begin
            expBad = isMem;
            if (isMem) expMemAdd = a;
            checkOutput({tag, ".done"}, 64'(done), 64'd1);
            checkIdleState(tag);
            tick();
            checkOutput({tag, ".done_pulse"}, 64'(done), 64'd0);
            return;
        end
        expMemAdd = a;
        expBad    = 1'b0;
        rdata     = isWr ? rand64() : tbMem[a[9:0]];
        for (int k = 0; k <= ackDelay; k++) begin
            checkOutput({tag, ".req_held"}, 64'(dmReq), 64'd1);
            checkOutput({tag, ".busy_held"}, 64'(busy), 64'd1);
            checkOutput({tag, ".no_done"}, 64'(done), 64'd0);
            checkOutput({tag, ".addr"}, dmAddr, a);
            checkOutput({tag, ".we"}, 64'(dmWe), 64'(isWr));
            if (isWr) checkOutput({tag, ".wdata"}, dmWdata, d);
            dmAck   = (k == ackDelay);
            dmRdata = (k == ackDelay) ? rdata : rand64();
            tick();
        end
        dmAck = 1'b0; dmRdata = rand64();
        if (isWr) tbMem[a[9:0]] = d;
        else expValM = rdata;
        checkOutput({tag, ".done"}, 64'(done), 64'd1);
        checkIdleState(tag);
        // A start presented during the completion cycle must be dropped.
        start = 1'b1; inCode = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd5;
        valE = 64'($urandom_range(0, WORDS - 1));
        tick();
        start = 1'b0;
        checkOutput({tag, ".resp_start_ignored.done"}, 64'(done), 64'd0);
        checkIdleState({tag, ".resp_start_ignored"});
    endtask

    function automatic logic [63:0] randAddr();
        if ($urandom_range(0, 3) == 0) return rand64() | 64'h400;
        return 64'($urandom_range(0, WORDS - 1));
    endfunction

    initial begin
        logic [3:0] codes [14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                                   4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd15};
        for (int i = 0; i < int'(WORDS); i++) tbMem[i] = rand64();
        tbMem[7] = 64'h77;

        // Reset held three cycles with random inputs.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom); inCode = 4'($urandom); valE = rand64(); valA = rand64();
            valP = rand64(); dmAck = 1'($urandom); dmRdata = rand64();
            tick();
        end
        checkOutput("reset.done", 64'(done), 64'd0);
        checkOutput("reset.addr", dmAddr, 64'd0);
        checkIdleState("reset");
        reset = 1'b0; start = 1'b0; dmAck = 1'b0;
        tick();

        applyStimulus("mrmovq_ack3", 4'd5, 64'd7, rand64(), rand64(), 2);
        applyStimulus("call_ack1", 4'd8, 64'd20, rand64(), 64'h1234, 0);
        applyStimulus("ret_readback", 4'd9, rand64(), 64'd20, rand64(), 1);
        applyStimulus("rmmovq_oor", 4'd4, 64'd1024, rand64(), rand64(), 0);
        applyStimulus("mrmovq_oor_max", 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, rand64(), rand64(), 0);

        // nop with start held high: every cycle is a fresh accepted start.
        start = 1'b1; inCode = 4'd1; valE = rand64(); valA = rand64();
        for (int i = 0; i < 5; i++) begin
            tick();
            expBad = 1'b0;
            checkOutput("nop_held.done", 64'(done), 64'd1);
            checkIdleState("nop_held");
        end
        start = 1'b0;
        tick();
        checkOutput("nop_held.release", 64'(done), 64'd0);

        // Stray ack while no request is outstanding.
        dmAck = 1'b1; dmRdata = rand64();
        tick();
        dmAck = 1'b0;
        checkOutput("stray_ack.done", 64'(done), 64'd0);
        checkIdleState("stray_ack");

        applyStimulus("pushq_top", 4'd10, 64'd1023, rand64(), rand64(), 0);
        applyStimulus("popq_top", 4'd11, rand64(), 64'd1023, rand64(), 0);
        applyStimulus("popq_ack_at_expiry", 4'd11, rand64(), 64'd3, rand64(), 3);

        for (int n = 0; n < 40; n++) begin
            applyStimulus("random", codes[$urandom_range(0, 13)], randAddr(), randAddr(), rand64(),
                          int'($urandom_range(0, 2)));
        end

        // Read with no ack at all.
        start = 1'b1; inCode = 4'd11; valA = 64'd3;
        tick();
        start = 1'b0;
        expMemAdd = 64'd3; expBad = 1'b0;
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < int'(TMO); i++) begin
            checkOutput("timeout.req_held", 64'(dmReq), 64'd1);
            tick();
        end
        expBad = 1'b1;
        checkOutput("timeout.done", 64'(done), 64'd1);
        checkIdleState("timeout");
        tick();
        start = 1'b1; inCode = 4'd11; valA = 64'd3;
        tick();
        start = 1'b0;
        expBad = 1'b0;
        checkOutput("reset_mid.req_before", 64'(dmReq), 64'd1);
        tick();
`else
        for (int i = 0; i < 8; i++) begin
            checkOutput("no_timeout.req_held", 64'(dmReq), 64'd1);
            checkOutput("no_timeout.no_done", 64'(done), 64'd0);
            tick();
        end
`endif
        reset = 1'b1;
        tick();
        expValM = '0; expMemAdd = '0; expBad = 1'b0;
        checkOutput("reset_mid.done", 64'(done), 64'd0);
        checkIdleState("reset_mid");
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
